// File: rtl/cam_seq_ctrl_if.sv
// Command/response bus between the pin-level command decode and cam_seq_ctrl.
// master: command source (drives cmd_*, receives rsp_*).
// slave : the sequencer (accepts cmd_*, produces rsp_*).
interface cam_seq_ctrl_if #(
  parameter int KEY_W  = 4,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [KEY_W-1:0]  cmd_key;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_hit;
  logic              rsp_evict;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_key, cmd_data,
    input  cmd_ready, rsp_valid, rsp_hit, rsp_evict, rsp_addr, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_key, cmd_data,
    output cmd_ready, rsp_valid, rsp_hit, rsp_evict, rsp_addr, rsp_data
  );
endinterface

// File: rtl/cam_seq_ctrl.sv
// cam_seq_ctrl: command sequencer and entry manager for the CAM core.
// Runs INSERT / LOOKUP / DELETE through SRCH -> EVAL -> (WR) -> RSP, owns the
// per-entry valid bits, lowest-free allocation and round-robin eviction.
// Optional feature: define CAM_CTRL_STATS_EN to build the saturating
// hit/miss counters; otherwise stat_hits/stat_miss are tied to zero.
module cam_seq_ctrl #(
  parameter int KEY_W  = 4,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  cam_seq_ctrl_if.slave     cmd,
  output logic              cam_search,
  output logic [KEY_W-1:0]  cam_key,
  input  logic [DEPTH-1:0]  cam_hit_vec,
  output logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_rdata,
  output logic              cam_we,
  output logic [DATA_W-1:0] cam_wdata,
  output logic [7:0]        stat_hits,
  output logic [7:0]        stat_miss
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SRCH = 3'd1;
  localparam logic [2:0] S_EVAL = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RSP  = 3'd4;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_LOOKUP = 2'b10;
  localparam logic [1:0] OP_DELETE = 2'b11;

  logic [2:0]        state;
  logic [1:0]        op_q;
  logic [KEY_W-1:0]  key_q;
  logic [DATA_W-1:0] data_q;
  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] victim;
  logic [ADDR_W-1:0] target;

  logic              rsp_hit_q;
  logic              rsp_evict_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [DEPTH-1:0]  match;
  logic              hit_any;
  logic [ADDR_W-1:0] hit_idx;
  logic              free_any;
  logic [ADDR_W-1:0] free_idx;
  logic [ADDR_W-1:0] ins_target;
  logic              ins_evict;

  // Priority-encode the lowest valid match and the lowest free entry.
  always_comb begin
    match    = cam_hit_vec & valid;
    hit_any  = |match;
    free_any = ~(&valid);
    hit_idx  = '0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = ADDR_W'(i);
      if (!valid[i]) free_idx = ADDR_W'(i);
    end
    ins_evict = !hit_any && !free_any;
    if (hit_any)       ins_target = hit_idx;
    else if (free_any) ins_target = free_idx;
    else               ins_target = victim;
  end

  assign cmd.cmd_ready = (state == S_IDLE) && ena;
  assign cam_search    = (state == S_SRCH);
  assign cam_we        = (state == S_WR);
  assign cmd.rsp_valid = (state == S_RSP);
  assign cmd.rsp_hit   = rsp_hit_q;
  assign cmd.rsp_evict = rsp_evict_q;
  assign cmd.rsp_addr  = rsp_addr_q;
  assign cmd.rsp_data  = rsp_data_q;
  assign cam_key       = key_q;
  assign cam_wdata     = data_q;

  // Core address: hit index while evaluating, allocated target while writing.
  always_comb begin
    cam_addr = '0;
    if (state == S_EVAL)    cam_addr = hit_idx;
    else if (state == S_WR) cam_addr = target;
  end

  // Sequencer FSM, entry valid bits, victim pointer and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= OP_NOP;
      key_q       <= '0;
      data_q      <= '0;
      valid       <= '0;
      victim      <= '0;
      target      <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_evict_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid && (cmd.cmd_op != OP_NOP)) begin
            op_q   <= cmd.cmd_op;
            key_q  <= cmd.cmd_key;
            data_q <= cmd.cmd_data;
            state  <= S_SRCH;
          end
        end
        S_SRCH: state <= S_EVAL;
        S_EVAL: begin
          rsp_hit_q   <= hit_any;
          rsp_evict_q <= 1'b0;
          rsp_addr_q  <= hit_idx;
          rsp_data_q  <= ((op_q == OP_LOOKUP) && hit_any) ? cam_rdata : '0;
          if (op_q == OP_INSERT) begin
            target      <= ins_target;
            rsp_addr_q  <= ins_target;
            rsp_evict_q <= ins_evict;
            if (ins_evict) victim <= victim + 1'b1;
            state <= S_WR;
          end else begin
            if ((op_q == OP_DELETE) && hit_any) valid[hit_idx] <= 1'b0;
            state <= S_RSP;
          end
        end
        S_WR: begin
          valid[target] <= 1'b1;
          state         <= S_RSP;
        end
        S_RSP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CAM_CTRL_STATS_EN
  logic [7:0] hits_q;
  logic [7:0] miss_q;

  // Saturating hit/miss counters, updated once per command at evaluation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hits_q <= '0;
      miss_q <= '0;
    end else if (ena && (state == S_EVAL)) begin
      if (hit_any) begin
        if (hits_q != 8'hFF) hits_q <= hits_q + 8'd1;
      end else begin
        if (miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
      end
    end
  end

  assign stat_hits = hits_q;
  assign stat_miss = miss_q;
`else
  assign stat_hits = '0;
  assign stat_miss = '0;
`endif

endmodule

// File: doc/cam_seq_ctrl.md
# cam_seq_ctrl

Command sequencer and entry manager for the associative-array (CAM) core. It accepts INSERT, LOOKUP and DELETE commands over a valid/ready handshake and sequences the core's search, read and write ports. It also owns the per-entry valid bits, free-entry allocation and round-robin replacement. It sits between the pin-level command decode and the CAM storage core inside the top-level user project.

## Interface
- KEY_W, 4, key width in bits
- DATA_W, 4, data width in bits
- DEPTH, 8, number of entries; power of two, ≥2; ADDR_W = $clog2(DEPTH) (localparam)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on the clk rising edge
- ena  in  1  clock enable; low freezes all state (reset still applies)
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 NOP, 01 INSERT, 10 LOOKUP, 11 DELETE
- cmd_key  in  KEY_W  search key
- cmd_data  in  DATA_W  INSERT payload
- cam_search  out  1  search strobe to core
- cam_key  out  KEY_W  key to core (search and write)
- cam_hit_vec  in  DEPTH  raw per-entry match from core; valid the cycle after cam_search
- cam_addr  out  ADDR_W  read/write address to core
- cam_rdata  in  DATA_W  combinational read data at cam_addr
- cam_we  out  1  write strobe; writes cam_key/cam_wdata at cam_addr
- cam_wdata  out  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_hit  out  1  key was present (masked by valid)
- rsp_evict  out  1  INSERT replaced a valid entry
- rsp_addr  out  ADDR_W  entry index involved
- rsp_data  out  DATA_W  LOOKUP data; 0 otherwise
- stat_hits  out  8  saturating hit count (see Configuration)
- stat_miss  out  8  saturating miss count (see Configuration)

## Operation
- FSM states: IDLE, SRCH, EVAL, WR, RSP. cmd_ready = (state==IDLE) & ena.
- IDLE: on cmd_valid & cmd_ready with op≠NOP, register op/key/data and go to SRCH. NOP is accepted and discarded.
- SRCH: drive cam_search=1 and cam_key=key; go to EVAL.
- EVAL:
  - match = cam_hit_vec & valid. Hit index is the lowest set bit.
  - Drive cam_addr = hit index. Register rsp_hit, rsp_addr and (LOOKUP hit only) rsp_data=cam_rdata.
  - LOOKUP and DELETE go to RSP. DELETE on hit clears valid[hit index]; DELETE on miss changes nothing.
  - INSERT goes to WR. Target entry:
    - hit → hit index;
    - else the lowest invalid entry;
    - else the entry at victim pointer, with rsp_evict=1 and victim advanced by 1 modulo DEPTH (DEPTH−1 wraps to 0).
- WR: drive cam_we=1, cam_addr=target, cam_key=key, cam_wdata=data. Set valid[target]. Go to RSP.
- RSP: rsp_valid=1 for one cycle, then go to IDLE.
- rsp_* fields hold their values until the next RSP.
- cam_search, cam_we and rsp_valid are decoded from state and are zero outside their states.
- ena low: no state, pointer, valid-bit or counter update. Decoded strobes stay asserted for the frozen state.

## Timing
- Accept edge = E0.
- LOOKUP and DELETE: rsp_valid high in the cycle after E2 (3 cycles after accept).
- INSERT: rsp_valid high in the cycle after E3 (4 cycles after accept).
- cmd_ready returns in the cycle after RSP. Issue interval: LOOKUP/DELETE 4 cycles, INSERT 5 cycles.
- Reset values: state IDLE, valid=0, victim=0, all outputs 0 (rsp_*, cam_*, stat_*). cmd_ready=1 in the first cycle after reset when ena=1.
- Reset mid-operation aborts the command with no response. cam_we is never high in the cycle following a reset edge.
- Multiple matching entries: the lowest index wins; the others are untouched.
- INSERT of a key already present never allocates and never evicts.

## Configuration
- CAM_CTRL_STATS_EN defined:
  - stat_hits increments at the EVAL edge for each LOOKUP/INSERT/DELETE hit; stat_miss increments for each miss.
  - Both saturate at 255 and clear on reset.
- CAM_CTRL_STATS_EN undefined: no counters are built and stat_hits/stat_miss are tied to 0.

## Test plan
- Reset, then LOOKUP key 5 → rsp_valid 3 cycles after accept, rsp_hit=0, rsp_data=0; cam_we never asserted.
- INSERT (3,0xA), then LOOKUP 3 → INSERT rsp_hit=0, rsp_addr=0, rsp_evict=0, cam_we pulses once; LOOKUP rsp_hit=1, rsp_addr=0, rsp_data=0xA.
- INSERT keys 0..7 (DEPTH=8), then INSERT key 9 → rsp_evict=1, rsp_addr=0; the next new key gives rsp_addr=1. After 8 more new keys the victim wraps to 0.
- INSERT (4,1), DELETE 4, LOOKUP 4 → DELETE rsp_hit=1 at 3-cycle latency; LOOKUP rsp_hit=0. The next new INSERT reuses the freed index.
- Assert rst_n low during WR of an INSERT → no rsp_valid, valid bits clear, cmd_ready=1 after release. Hold ena low 5 cycles mid-LOOKUP → response delayed by exactly 5 cycles.
- With CAM_CTRL_STATS_EN defined: 300 LOOKUP hits → stat_hits=255. Without it: stat_hits=stat_miss=0 throughout.
